// File: rtl/half_subtracter_pkg.sv
// half_subtracter_pkg: default sizes and the per-lane result type shared by the subtracter files
package half_subtracter_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
  typedef struct packed {
    logic d;
    logic b_out;
  } lane_t;
endpackage

// File: rtl/half_subtracter_cell.sv
// half_subtracter_cell: one combinational 1-bit half-subtracter lane
module half_subtracter_cell
  import half_subtracter_pkg::*;
(
  input  logic  i_a,
  input  logic  i_b,
  output lane_t o_res
);
  assign o_res = '{d: i_a ^ i_b, b_out: ~i_a & i_b};
endmodule

// File: rtl/half_subtracter.sv
// half_subtracter: WIDTH independent half-subtracter lanes, combinational plus registered results
// Optional saturating borrow counter under HALF_SUBTRACTER_STATS_EN.
module half_subtracter
  import half_subtracter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B_out,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] D_q,
  output logic [WIDTH-1:0] B_out_q,
  output logic             out_valid
`ifdef HALF_SUBTRACTER_STATS_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);
  lane_t w_res [WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtracter_cell u_cell (
      .i_a  (A[i]),
      .i_b  (B[i]),
      .o_res(w_res[i])
    );
    assign D[i]     = w_res[i].d;
    assign B_out[i] = w_res[i].b_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      D_q       <= '0;
      B_out_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D_q     <= D;
        B_out_q <= B_out;
      end
    end
  end
`ifdef HALF_SUBTRACTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      borrow_cnt <= '0;
    else if (in_valid && |B_out && !(&borrow_cnt))
      borrow_cnt <= borrow_cnt + 1'b1;
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif
endmodule

// File: tb/tb_half_subtracter.sv
// tb_half_subtracter: directed-vector self-checking bench for half_subtracter
// Exercises the stats counter too when HALF_SUBTRACTER_STATS_EN is defined.
module tb_half_subtracter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [0:0] A = '0, B = '0, D, B_out, D_q, B_out_q;
  logic       out_valid;
  logic [3:0] a4 = '0, b4 = '0, d4, b4_out, d4_q, b4_out_q;
  logic       out_valid4;
  int         n_checks = 0;
  int         n_fail = 0;
`ifdef HALF_SUBTRACTER_STATS_EN
  logic [1:0] borrow_cnt;
`endif

  always #5 clk = ~clk;

  half_subtracter #(.WIDTH(1), .CNT_W(2)) u_dut (
    .A(A), .B(B), .D(D), .B_out(B_out), .clk(clk), .rst(rst), .in_valid(in_valid),
    .D_q(D_q), .B_out_q(B_out_q), .out_valid(out_valid)
`ifdef HALF_SUBTRACTER_STATS_EN
    , .borrow_cnt(borrow_cnt)
`endif
  );

  half_subtracter #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .A(a4), .B(b4), .D(d4), .B_out(b4_out), .clk(clk), .rst(rst), .in_valid(in_valid),
    .D_q(d4_q), .B_out_q(b4_out_q), .out_valid(out_valid4)
`ifdef HALF_SUBTRACTER_STATS_EN
    , .borrow_cnt()
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {A,B} -> {D,B_out}: 00->00, 01->11, 10->10, 11->00
  logic [1:0] comb_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] comb_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
  // back-to-back accepted vectors and their registered {D_q,B_out_q}
  logic [1:0] b2b_in   [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
  logic [1:0] b2b_exp  [4] = '{2'b00, 2'b11, 2'b00, 2'b10};

  initial begin
    for (int i = 0; i < 4; i++) begin
      {A, B} = comb_in[i];
      #1 check($sformatf("comb_%0d", i), {D, B_out}, comb_exp[i]);
      #9;
    end
    rst = 1'b1; in_valid = 1'b1; A = 1'b1; B = 1'b0;
    tick();
    tick();
    check("rst_dq", D_q, 0);
    check("rst_bq", B_out_q, 0);
    check("rst_ov", out_valid, 0);
    check("rst_comb", {D, B_out}, 2'b10);
    rst = 1'b0; A = 1'b0; B = 1'b1;
    tick();
    check("first_dq", D_q, 1);
    check("first_bq", B_out_q, 1);
    check("first_ov", out_valid, 1);
    A = 1'b1; B = 1'b0;
    tick();
    check("acc_regs", {D_q, B_out_q}, 2'b10);
    check("acc_ov", out_valid, 1);
    in_valid = 1'b0; A = 1'b0; B = 1'b1;
    tick();
    check("hold_regs", {D_q, B_out_q}, 2'b10);
    check("hold_ov", out_valid, 0);
    check("hold_comb", {D, B_out}, 2'b11);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {A, B} = b2b_in[i];
      tick();
      check($sformatf("b2b_regs_%0d", i), {D_q, B_out_q}, b2b_exp[i]);
      check($sformatf("b2b_ov_%0d", i), out_valid, 1);
    end
    A = 1'b0; B = 1'b1;
    tick();
    rst = 1'b1; A = 1'b1; B = 1'b0;
    tick();
    check("mid_rst_regs", {D_q, B_out_q, out_valid}, 3'b000);
    check("mid_rst_comb", {D, B_out}, 2'b10);
    A = 1'b0; B = 1'b1;
    #1 check("mid_rst_track", {D, B_out}, 2'b11);
    rst = 1'b0;
    a4 = 4'b1010; b4 = 4'b0110;
    tick();
    check("w4_d", d4, 4'b1100);
    check("w4_b", b4_out, 4'b0100);
    check("w4_dq", d4_q, 4'b1100);
    check("w4_bq", b4_out_q, 4'b0100);
    a4 = 4'b0000; b4 = 4'b1111;
    #1 check("w4_all_borrow", {d4, b4_out}, 8'hFF);
    a4 = 4'b1111; b4 = 4'b0101;
    #1 check("w4_no_borrow", {d4, b4_out}, 8'hA0);
`ifdef HALF_SUBTRACTER_STATS_EN
    rst = 1'b1; in_valid = 1'b1;
    tick();
    check("cnt_rst", borrow_cnt, 0);
    rst = 1'b0; A = 1'b0; B = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("cnt_%0d", i), borrow_cnt, (i < 3) ? i + 1 : 3);
    end
    A = 1'b1; B = 1'b0;
    rst = 1'b1;
    tick();
    check("cnt_clear", borrow_cnt, 0);
    rst = 1'b0; A = 1'b1; B = 1'b1;
    tick();
    check("cnt_no_borrow", borrow_cnt, 0);
    A = 1'b0; B = 1'b1; in_valid = 1'b0;
    tick();
    check("cnt_not_accepted", borrow_cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/half_subtracter.md
HALF_SUBTRACTER -- requirements
Module: half_subtracter

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning number of independent 1-bit subtracter lanes.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of borrow statistics counter.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port A, input, WIDTH bits; minuend, one bit per lane.
REQ-006 SHALL have port B, input, WIDTH bits; subtrahend, one bit per lane.
REQ-007 SHALL have port D, output, WIDTH bits; combinational difference per lane.
REQ-008 SHALL have port B_out, output, WIDTH bits; combinational borrow-out per lane.
REQ-009 SHALL have port in_valid, input, 1 bit; qualifies A/B for the registered path.
REQ-010 SHALL have port D_q, output, WIDTH bits; registered difference.
REQ-011 SHALL have port B_out_q, output, WIDTH bits; registered borrow.
REQ-012 SHALL have port out_valid, output, 1 bit; D_q/B_out_q hold a fresh result.
REQ-013 SHALL declare ports in order A, B, D, B_out, clk, rst, in_valid, D_q, B_out_q, out_valid, so positional four-port hookups bind A, B, D, B_out.

Function
REQ-014 SHALL compute per lane i: D[i] = A[i] XOR B[i]; B_out[i] = (NOT A[i]) AND B[i].
REQ-015 SHALL produce D/B_out with zero latency, independent of clk, rst, in_valid; valid with clk/rst undriven.
REQ-016 Truth table per lane (A,B -> D,B_out): 0,0->0,0; 0,1->1,1; 1,0->1,0; 1,1->0,0.
REQ-017 SHALL capture D and B_out into D_q/B_out_q on a rising clk edge when in_valid=1 (latency 1 cycle).
REQ-018 SHALL hold D_q/B_out_q unchanged when in_valid=0.
REQ-019 SHALL drive out_valid = in_valid registered one cycle (1 for exactly the cycle after each accepted input).
REQ-020 Lanes SHALL be fully independent; no borrow propagates between lanes.
REQ-021 Back-to-back in_valid SHALL be accepted every cycle; no backpressure.

Reset
REQ-022 On rising clk with rst=1: D_q=0, B_out_q=0, out_valid=0; rst takes priority over in_valid.
REQ-023 rst SHALL NOT affect combinational D/B_out.
REQ-024 First accepted input SHALL be the one sampled in the first cycle with rst=0.

Configuration
REQ-025 Macro HALF_SUBTRACTER_STATS_EN: when defined, SHALL add output borrow_cnt (CNT_W bits), incremented by 1 on each accepted input (in_valid=1) with any B_out bit set, saturating at all-ones, cleared to 0 by rst.
REQ-026 When HALF_SUBTRACTER_STATS_EN is undefined, borrow_cnt and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package half_subtracter_pkg SHALL hold default WIDTH, default CNT_W and a lane-result struct typedef (d, b_out).
REQ-028 Sub-module half_subtracter_cell SHALL implement one combinational lane (REQ-014), instantiated WIDTH times via generate.
REQ-029 Registers and the optional counter SHALL reside in the top module.

Verification
REQ-030 WIDTH=1, no clock: A,B = 00,01,10,11 at 10-unit steps -> D,B_out = 00,11,10,00.
REQ-031 rst=1 two cycles, in_valid=1 -> D_q=0, B_out_q=0, out_valid=0; release, A=0,B=1 -> next cycle D_q=1, B_out_q=1, out_valid=1.
REQ-032 in_valid=1 with A=1,B=0 then in_valid=0 with A=0,B=1 -> D_q=1, B_out_q=0 held; out_valid 1 then 0.
REQ-033 WIDTH=4, A=4'b1010, B=4'b0110 -> D=4'b1100, B_out=4'b0100.
REQ-034 STATS_EN, CNT_W=2: five accepted inputs A=0,B=1 -> borrow_cnt 1,2,3,3,3; rst -> 0.
REQ-035 rst asserted mid-stream with in_valid=1 -> registered outputs 0 next edge; D/B_out keep tracking inputs.
